bsg_multi_fifo_linked_pool: RTL and testbench
=============================================

Name: bsg_multi_fifo_linked_pool

Overview:
- Implements fifos_p logical FIFOs that share one pool of total_els_p storage slots.
- Each FIFO is a linked list. Per-FIFO head/tail registers point into a shared next-pointer memory (1R1W, synchronous read), and a free-ID pool hands out slot addresses.
- Payload storage is external. The block only supplies the write address (waddr_o) and the read address (raddr_o).
- Internals: one-hot decode of the enqueue and dequeue IDs, a lowest-free-first ID pool, and the next-pointer RAM.

Parameters:
- fifos_p, default 4: number of logical FIFOs. lg_fifos = safe_clog2(fifos_p).
- total_els_p, default 16: number of shared slots. lg_els = safe_clog2(total_els_p).

Ports:
- clk_i, in, 1: clock; all state updates on the rising edge.
- reset_n_i, in, 1: synchronous, active-low reset.
- v_i, in, 1: enqueue request.
- enq_id_i, in, lg_fifos: target FIFO of the enqueue.
- ready_and_o, out, 1: a free slot exists. Enqueue fires on v_i & ready_and_o.
- v_o, out, fifos_p: bit f = FIFO f is non-empty.
- deq_id_i, in, lg_fifos: FIFO to dequeue.
- yumi_i, in, 1: dequeue fires. Legal only when v_o[deq_id_i]=1.
- raddr_o, out, lg_els: payload read address. Valid when yumi_i; equals 0 when yumi_i=0.
- waddr_o, out, lg_els: payload write address, i.e. the currently allocatable slot. Valid when ready_and_o.

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - v_o=0; all head/tail registers = 0; no pending pointer read.
  - All slots are free; the pending dealloc register is cleared.
  - After reset: ready_and_o=1 and waddr_o=0.
- ID pool:
  - ready_and_o = any slot free. waddr_o = lowest-numbered free slot.
  - A fired enqueue marks that slot busy at the clock edge.
- Dealloc latency:
  - A dequeue at cycle t registers raddr_o as the dealloc ID.
  - At cycle t+1 that ID is treated as free combinationally, so it can be allocated in cycle t+1. It is then freed for good at the edge unless allocated.
  - Consequence: when full, yumi at t leaves ready_and_o=0 during t, and ready_and_o=1 at t+1 (one-cycle bubble). This also guarantees no payload same-address read and write in one cycle.
- Per-FIFO state: v, head, tail, pending_read, and head_eff = pending_read ? next_mem_rdata : head.
- Enqueue to FIFO f (fires):
  - If v_f=1: write next_mem[tail_f] = new slot.
  - tail_f <= new slot; v_f <= 1.
  - If v_f=0, or FIFO f is singleton (head_eff==tail_f) and dequeued the same cycle: head_f <= new slot.
- Dequeue of FIFO f:
  - raddr_o = head_eff of f.
  - If head_eff != tail_f: read next_mem[head_eff] (synchronous) and set pending_read for the next cycle. The next cycle's head_eff is the read data, bypassed combinationally, so back-to-back dequeues of the same FIFO work every cycle. head_f latches the read data at the following edge.
  - If singleton and no simultaneous enqueue to f: v_f <= 0.
  - A simultaneous enqueue to the same FIFO keeps v_f=1.
- Simultaneous enqueue and dequeue on different FIFOs are independent.
- Next-pointer memory:
  - At most one write and one read per cycle.
  - The read address never equals the write address in the same cycle; no same-address behaviour is required.
- Illegal input: dequeue of an empty FIFO has undefined results. Simulation asserts flag non-onehot0 link writes/reads and same-address pointer or payload R/W.

Test Plan:
1. Reset, then idle -> ready_and_o=1, waddr_o=0, v_o=4'b0000, raddr_o=0.
2. Enqueue FIFO0 three consecutive cycles, then FIFO1 once -> waddr_o 0,1,2,3; v_o=4'b0011. Then dequeue FIFO0 three consecutive cycles -> raddr_o 0,1,2 (bypassed link reads); v_o[0]=0 after the third dequeue; FIFO1 still yields raddr_o=3.
3. Fill all 16 slots across FIFOs -> ready_and_o=0. Dequeue FIFO2 whose head is slot 5 -> ready_and_o stays 0 that cycle; next cycle ready_and_o=1, waddr_o=5.
4. FIFO3 holds only slot 7; in one cycle dequeue FIFO3 and enqueue FIFO3 (waddr_o=8) -> raddr_o=7, v_o[3] stays 1; the next dequeue of FIFO3 gives raddr_o=8.
5. Interleave: enqueue FIFO0 slot a, FIFO1 slot b, FIFO0 slot c; dequeue FIFO0, FIFO1, FIFO0 on consecutive cycles -> raddr_o a, b, c. Freed slots are reallocated lowest-first.
6. Assert reset_n_i=0 mid-traffic for one cycle -> next cycle v_o=0, ready_and_o=1, waddr_o=0; prior contents are discarded.

Source files
------------

// File: rtl/bsg_multi_fifo_linked_pool.sv
// bsg_multi_fifo_linked_pool
// Several logical FIFOs share one pool of slots. Each FIFO is a linked list
// through a shared next-pointer RAM. Payload storage is external; this block
// only supplies the payload write and read addresses.
module bsg_multi_fifo_linked_pool #(
   parameter  int fifos_p     = 4,
   parameter  int total_els_p = 16,
   localparam int lg_fifos_lp = (fifos_p > 1) ? $clog2(fifos_p) : 1,
   localparam int lg_els_lp   = (total_els_p > 1) ? $clog2(total_els_p) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   v_i,
   input  logic [lg_fifos_lp-1:0] enq_id_i,
   output logic                   ready_and_o,
   output logic [fifos_p-1:0]     v_o,
   input  logic [lg_fifos_lp-1:0] deq_id_i,
   input  logic                   yumi_i,
   output logic [lg_els_lp-1:0]   raddr_o,
   output logic [lg_els_lp-1:0]   waddr_o
);

   // per-FIFO list state
   logic [fifos_p-1:0]                v_r, pend_r;
   logic [fifos_p-1:0][lg_els_lp-1:0] head_r, tail_r, head_eff;

   // slot pool; a freed slot spends one cycle in the dealloc register
   logic [total_els_p-1:0] free_r, free_eff, alloc_oh;
   logic                   dealloc_v_r;
   logic [lg_els_lp-1:0]   dealloc_id_r;
   logic [lg_els_lp-1:0]   alloc_id;

   // next-pointer RAM (1R1W, registered read)
   logic [lg_els_lp-1:0] next_mem [total_els_p];
   logic [lg_els_lp-1:0] mem_rdata_r;
   logic                 mem_we, mem_re;
   logic [lg_els_lp-1:0] mem_waddr, mem_raddr;

   logic [fifos_p-1:0]   enq_oh, deq_oh;
   logic                 enq_fire, deq_single;
   logic [lg_els_lp-1:0] deq_head, deq_tail;

   assign enq_fire = v_i & ready_and_o;

   // one-hot decode of the enqueue and dequeue targets
   always_comb begin
      enq_oh = '0;
      deq_oh = '0;
      for (int f = 0; f < fifos_p; f++) begin
         enq_oh[f] = enq_fire && (enq_id_i == lg_fifos_lp'(f));
         deq_oh[f] = yumi_i && (deq_id_i == lg_fifos_lp'(f));
      end
   end

   // pool view: last cycle's dealloc counts as free; pick the lowest free slot
   always_comb begin
      free_eff = free_r;
      if (dealloc_v_r) free_eff[dealloc_id_r] = 1'b1;
      alloc_id = '0;
      for (int i = total_els_p - 1; i >= 0; i--)
         if (free_eff[i]) alloc_id = lg_els_lp'(i);
      alloc_oh = '0;
      if (enq_fire) alloc_oh[alloc_id] = 1'b1;
   end

   assign ready_and_o = |free_eff;
   assign waddr_o     = alloc_id;

   // a pending link read overrides the stale head register
   always_comb begin
      for (int f = 0; f < fifos_p; f++)
         head_eff[f] = pend_r[f] ? mem_rdata_r : head_r[f];
   end

   assign deq_head   = head_eff[deq_id_i];
   assign deq_tail   = tail_r[deq_id_i];
   assign deq_single = (deq_head == deq_tail);

   assign mem_we    = enq_fire & v_r[enq_id_i];
   assign mem_waddr = tail_r[enq_id_i];
   assign mem_re    = yumi_i & ~deq_single;
   assign mem_raddr = deq_head;

   assign raddr_o = yumi_i ? deq_head : '0;
   assign v_o     = v_r;

   // pool registers: commit allocation, stage the dequeued slot for release
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         free_r       <= '1;
         dealloc_v_r  <= 1'b0;
         dealloc_id_r <= '0;
      end else begin
         free_r       <= free_eff & ~alloc_oh;
         dealloc_v_r  <= yumi_i;
         dealloc_id_r <= deq_head;
      end
   end

   // per-FIFO head/tail/valid update
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         v_r    <= '0;
         pend_r <= '0;
         head_r <= '0;
         tail_r <= '0;
      end else begin
         for (int f = 0; f < fifos_p; f++) begin
            head_r[f] <= head_eff[f];
            pend_r[f] <= deq_oh[f] & ~deq_single;
            if (deq_oh[f] && deq_single) v_r[f] <= 1'b0;
            if (enq_oh[f]) begin
               tail_r[f] <= alloc_id;
               v_r[f]    <= 1'b1;
               // empty list, or the only element is leaving this cycle
               if (!v_r[f] || (deq_oh[f] && deq_single)) head_r[f] <= alloc_id;
            end
         end
      end
   end

   // next-pointer RAM: link append on enqueue, successor fetch on dequeue
   always_ff @(posedge clk_i) begin
      if (mem_we) next_mem[mem_waddr] <= alloc_id;
      if (mem_re) mem_rdata_r <= next_mem[mem_raddr];
   end

   // simulation checks on link and payload port usage
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert ($onehot0(enq_oh & v_r));
         assert ($onehot0(deq_oh & {fifos_p{~deq_single}}));
         assert (!(mem_we && mem_re && (mem_waddr == mem_raddr)));
         assert (!(enq_fire && yumi_i && (waddr_o == raddr_o)));
      end
   end

endmodule

// File: tb/tb_bsg_multi_fifo_linked_pool.sv
// Scoreboard bench for bsg_multi_fifo_linked_pool. The driver advances a
// queue-based model of the FIFOs and slot pool and pushes the expected
// per-cycle outputs; a monitor pops and compares at the falling edge.
module tb_bsg_multi_fifo_linked_pool;
   localparam int NF = 4;
   localparam int NE = 16;
   localparam int LF = 2;
   localparam int LE = 4;

   logic          clk_i = 1'b0;
   logic          reset_n_i = 1'b0;
   logic          v_i = 1'b0;
   logic [LF-1:0] enq_id_i = '0;
   logic          ready_and_o;
   logic [NF-1:0] v_o;
   logic [LF-1:0] deq_id_i = '0;
   logic          yumi_i = 1'b0;
   logic [LE-1:0] raddr_o;
   logic [LE-1:0] waddr_o;

   bsg_multi_fifo_linked_pool #(.fifos_p(NF), .total_els_p(NE)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .enq_id_i(enq_id_i),
      .ready_and_o(ready_and_o), .v_o(v_o), .deq_id_i(deq_id_i),
      .yumi_i(yumi_i), .raddr_o(raddr_o), .waddr_o(waddr_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit ready;
      int waddr;
      int vo;
      int raddr;
      string tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model: slot lists per FIFO, free set, slot released last cycle
   int          fq[NF][$];
   bit [NE-1:0] mfree;
   bit          mdv;
   int          mdslot;

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      mfree = '1;
      mdv = 1'b0;
      mdslot = 0;
      for (int f = 0; f < NF; f++) fq[f].delete();
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      reset_n_i = 1'b0;
      v_i = 1'b0;
      yumi_i = 1'b0;
      model_reset();
   endtask

   // one clock of stimulus; dequeue of an empty FIFO is suppressed
   task automatic cycle(input bit v, input int e, input bit y_req, input int d, input string tag);
      bit [NE-1:0] fe;
      bit y;
      exp_t x;
      @(posedge clk_i); #1;
      y = y_req && (fq[d].size() != 0);
      fe = mfree;
      if (mdv) fe[mdslot] = 1'b1;
      x.ready = 1'b0;
      x.waddr = 0;
      for (int i = NE - 1; i >= 0; i--)
         if (fe[i]) begin x.ready = 1'b1; x.waddr = i; end
      x.vo = 0;
      for (int f = 0; f < NF; f++) if (fq[f].size() != 0) x.vo |= (1 << f);
      x.raddr = y ? fq[d][0] : 0;
      x.tag = tag;
      reset_n_i = 1'b1;
      v_i = v;
      enq_id_i = LF'(e);
      yumi_i = y;
      deq_id_i = LF'(d);
      exp_q.push_back(x);
      mdv = y;
      mdslot = x.raddr;
      if (y) void'(fq[d].pop_front());
      if (v && x.ready) begin
         fq[e].push_back(x.waddr);
         fe[x.waddr] = 1'b0;
      end
      mfree = fe;
   endtask

   // monitor: compare one expected record per driven cycle
   initial begin
      exp_t x;
      forever begin
         @(negedge clk_i);
         if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk({x.tag, " ready_and_o"}, int'(ready_and_o), int'(x.ready));
            if (x.ready) chk({x.tag, " waddr_o"}, int'(waddr_o), x.waddr);
            chk({x.tag, " v_o"}, int'(v_o), x.vo);
            chk({x.tag, " raddr_o"}, int'(raddr_o), x.raddr);
         end
      end
   end

   initial begin
      int pe, pd;
      model_reset();
      do_reset();

      // reset and idle
      cycle(0, 0, 0, 0, "idle");
      cycle(0, 0, 0, 0, "idle");

      // FIFO0 x3, FIFO1 x1, then back-to-back dequeues
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, "enq0");
      cycle(1, 1, 0, 0, "enq1");
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "deq0");
      cycle(0, 0, 1, 1, "deq1");
      cycle(0, 0, 0, 0, "idle");

      // fill the pool so FIFO2 heads at slot 5, then release it while full
      do_reset();
      for (int i = 0; i < NE; i++)
         cycle(1, (i < 5) ? (i % 2) : ((i % 2) ? 2 : 3), 0, 0, "fill");
      cycle(1, 0, 1, 2, "full_deq");
      cycle(1, 0, 0, 0, "bubble");
      cycle(0, 0, 0, 0, "idle");

      // singleton FIFO3 dequeued and enqueued in the same cycle
      do_reset();
      for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, "pre0");
      cycle(1, 3, 0, 0, "pre3");
      cycle(1, 3, 1, 3, "single_swap");
      cycle(0, 0, 1, 3, "deq3");

      // interleaved FIFOs and lowest-first reuse
      do_reset();
      cycle(1, 0, 0, 0, "il_a");
      cycle(1, 1, 0, 0, "il_b");
      cycle(1, 0, 0, 0, "il_c");
      cycle(0, 0, 1, 0, "il_deq0");
      cycle(0, 0, 1, 1, "il_deq1");
      cycle(0, 0, 1, 0, "il_deq0");
      cycle(1, 2, 0, 0, "reuse");
      cycle(1, 2, 0, 0, "reuse");

      // randomized traffic with fill-heavy and drain-heavy phases and
      // occasional one-cycle resets
      for (int ph = 0; ph < 8; ph++) begin
         pe = (ph % 2) ? 35 : 85;
         pd = (ph % 2) ? 85 : 35;
         for (int c = 0; c < 250; c++) begin
            cycle($urandom_range(99) < pe, $urandom_range(NF - 1),
                  $urandom_range(99) < pd, $urandom_range(NF - 1), "rand");
            if (c == 137 && ph % 3 == 1) do_reset();
         end
      end

      repeat (3) @(posedge clk_i);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
